// File: rtl/rtc_cnt_if.sv
// rtl/rtc_cnt_if.sv - control and status bundle between software side and RTC time-base counter
interface rtc_cnt_if #(
    parameter int PRESCALE_W = 16
);
    logic                  cnt_en_req;
    logic [PRESCALE_W-1:0] prescale_val;
    logic                  load_req;
    logic [31:0]           load_val;
    logic                  wrap_clr;
    logic                  load_ack;
    logic                  cnt_en;
    logic [31:0]           count_val;
    logic                  tick;
    logic                  wrap_flag;

    modport master (
        output cnt_en_req, prescale_val, load_req, load_val, wrap_clr,
        input  load_ack, cnt_en, count_val, tick, wrap_flag
    );

    modport slave (
        input  cnt_en_req, prescale_val, load_req, load_val, wrap_clr,
        output load_ack, cnt_en, count_val, tick, wrap_flag
    );
endinterface

// File: rtl/rtc_cnt.sv
// rtl/rtc_cnt.sv - prescaled 32-bit RTC time-base counter with load handshake and sticky wrap flag
module rtc_cnt #(
    parameter int PRESCALE_W = 16
) (
    input  logic    i_rtc_ext_clk,
    input  logic    rtc_por_rst_n,
    rtc_cnt_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, LOAD, LDWT} state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [PRESCALE_W-1:0] r_pre_cnt;
    logic [PRESCALE_W-1:0] w_pre_cnt_nxt;
    logic [31:0]           r_count_val;
    logic [31:0]           w_count_nxt;
    logic                  r_cnt_en;
    logic                  r_tick;
    logic                  w_tick_nxt;
    logic                  r_load_ack;
    logic                  w_ack_nxt;
    logic                  r_wrap_flag;
    logic                  w_wrap_set;
    logic [32:0]           w_inc;

    assign w_inc = {1'b0, r_count_val} + 33'd1;

    always_comb begin
        w_state_nxt   = r_state;
        w_pre_cnt_nxt = r_pre_cnt;
        w_count_nxt   = r_count_val;
        w_tick_nxt    = 1'b0;
        w_ack_nxt     = 1'b0;
        w_wrap_set    = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.load_req)
                    w_state_nxt = LOAD;
                else if (bus.cnt_en_req)
                    w_state_nxt = RUN;
            end
            RUN: begin
                // a pending load wins over the increment due this cycle
                if (bus.load_req) begin
                    w_state_nxt = LOAD;
                end else if (!bus.cnt_en_req) begin
                    w_state_nxt   = IDLE;
                    w_pre_cnt_nxt = '0;
                end else if (r_pre_cnt >= bus.prescale_val) begin
                    w_pre_cnt_nxt = '0;
                    w_count_nxt   = w_inc[31:0];
                    w_tick_nxt    = 1'b1;
                    w_wrap_set    = w_inc[32];
                end else begin
                    w_pre_cnt_nxt = r_pre_cnt + PRESCALE_W'(1);
                end
            end
            LOAD: begin
                w_count_nxt   = bus.load_val;
                w_pre_cnt_nxt = '0;
                w_ack_nxt     = 1'b1;
                w_state_nxt   = LDWT;
            end
            LDWT: begin
                if (!bus.load_req)
                    w_state_nxt = bus.cnt_en_req ? RUN : IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_rtc_ext_clk or negedge rtc_por_rst_n) begin
        if (!rtc_por_rst_n) begin
            r_state     <= IDLE;
            r_pre_cnt   <= '0;
            r_count_val <= '0;
            r_cnt_en    <= 1'b0;
            r_tick      <= 1'b0;
            r_load_ack  <= 1'b0;
            r_wrap_flag <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_pre_cnt   <= w_pre_cnt_nxt;
            r_count_val <= w_count_nxt;
            r_cnt_en    <= (r_state == RUN);
            r_tick      <= w_tick_nxt;
            r_load_ack  <= w_ack_nxt;
            // set beats clear
            r_wrap_flag <= w_wrap_set | (r_wrap_flag & ~bus.wrap_clr);
        end
    end

    assign bus.cnt_en    = r_cnt_en;
    assign bus.count_val = r_count_val;
    assign bus.tick      = r_tick;
    assign bus.load_ack  = r_load_ack;
    assign bus.wrap_flag = r_wrap_flag;
endmodule

// File: tb/tb_rtc_cnt.sv
// tb/tb_rtc_cnt.sv - directed and randomized checks of rtc_cnt against a behavioural model
module tb_rtc_cnt;
    logic clk = 1'b0;
    logic rst_n;

    rtc_cnt_if #(.PRESCALE_W(16)) u_if ();

    rtc_cnt #(.PRESCALE_W(16)) u_dut (
        .i_rtc_ext_clk (clk),
        .rtc_por_rst_n (rst_n),
        .bus           (u_if.slave)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int n_ack   = 0;

    // behavioural model: mode 0 idle, 1 counting, 2 loading, 3 waiting for request release
    int          m_mode;
    int          m_pre;
    logic [31:0] m_cnt;
    logic        m_en, m_tick, m_ack, m_wrap;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_pre = 0; m_cnt = '0;
        m_en = 0; m_tick = 0; m_ack = 0; m_wrap = 0;
    endtask

    task automatic model_edge();
        longint sum;
        logic    wrapped;
        int      mode_now;
        if (!rst_n) begin
            model_reset();
            return;
        end
        mode_now = m_mode;
        wrapped  = 1'b0;
        m_en     = (mode_now == 1);
        m_tick   = 1'b0;
        m_ack    = 1'b0;
        case (mode_now)
            0: if (u_if.load_req) m_mode = 2; else if (u_if.cnt_en_req) m_mode = 1;
            1: begin
                if (u_if.load_req) m_mode = 2;
                else if (!u_if.cnt_en_req) begin m_mode = 0; m_pre = 0; end
                else if (m_pre >= int'(u_if.prescale_val)) begin
                    sum     = longint'(m_cnt) + 1;
                    wrapped = (sum == 64'h1_0000_0000);
                    m_cnt   = 32'(sum % 64'h1_0000_0000);
                    m_pre   = 0;
                    m_tick  = 1'b1;
                end else m_pre = m_pre + 1;
            end
            2: begin m_cnt = u_if.load_val; m_pre = 0; m_ack = 1'b1; m_mode = 3; end
            default: if (!u_if.load_req) m_mode = u_if.cnt_en_req ? 1 : 0;
        endcase
        if (wrapped) m_wrap = 1'b1;
        else if (u_if.wrap_clr) m_wrap = 1'b0;
    endtask

    task automatic check_all();
        chk("cnt_en", u_if.cnt_en, m_en);
        chk("count_val", u_if.count_val, m_cnt);
        chk("tick", u_if.tick, m_tick);
        chk("load_ack", u_if.load_ack, m_ack);
        chk("wrap_flag", u_if.wrap_flag, m_wrap);
        if (u_if.load_ack === 1'b1) n_ack++;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    initial begin
        int          guard;
        int          ack_base;
        logic [31:0] saved;

        rst_n = 1'b0;
        u_if.cnt_en_req = 0; u_if.prescale_val = 0; u_if.load_req = 0;
        u_if.load_val = 0; u_if.wrap_clr = 0;
        model_reset();
        #2;
        check_all();
        step(); step();
        rst_n = 1'b1;

        // 1: prescale 3, enable
        u_if.prescale_val = 16'd3; u_if.cnt_en_req = 1;
        step();
        chk("t1_en_lat1", u_if.cnt_en, 1'b0);
        step();
        chk("t1_en_lat2", u_if.cnt_en, 1'b1);
        repeat (7) step();
        chk("t1_cnt2", u_if.count_val, 32'd2);
        chk("t1_tick", u_if.tick, 1'b1);

        // 2: load while running at 5
        guard = 0;
        while (m_cnt != 32'd5 && guard < 100) begin step(); guard++; end
        chk("t2_reach5", guard < 100, 1'b1);
        u_if.load_req = 1; u_if.load_val = 32'h1234_5678;
        step();
        chk("t2_no_inc", u_if.count_val, 32'd5);
        step();
        chk("t2_ack", u_if.load_ack, 1'b1);
        chk("t2_val", u_if.count_val, 32'h1234_5678);
        u_if.load_req = 0;
        repeat (4) step();
        chk("t2_hold", u_if.count_val, 32'h1234_5678);
        step();
        chk("t2_inc", u_if.count_val, 32'h1234_5679);

        // 3: wrap with prescale 0
        u_if.prescale_val = 16'd0; u_if.load_req = 1; u_if.load_val = 32'hFFFF_FFFE;
        step(); step();
        u_if.load_req = 0;
        step(); step();
        chk("t3_ffff", u_if.count_val, 32'hFFFF_FFFF);
        u_if.wrap_clr = 1;
        step();
        chk("t3_zero", u_if.count_val, 32'd0);
        chk("t3_set_beats_clr", u_if.wrap_flag, 1'b1);
        step();
        chk("t3_cleared", u_if.wrap_flag, 1'b0);
        u_if.wrap_clr = 0;

        // 4: disable at pre_cnt 2, re-enable
        u_if.prescale_val = 16'd3;
        guard = 0;
        while (!(m_mode == 1 && m_pre == 2) && guard < 100) begin step(); guard++; end
        chk("t4_reach_pre2", guard < 100, 1'b1);
        u_if.cnt_en_req = 0;
        step();
        saved = m_cnt;
        repeat (3) step();
        chk("t4_hold", u_if.count_val, saved);
        chk("t4_en_low", u_if.cnt_en, 1'b0);
        u_if.cnt_en_req = 1;
        step();
        repeat (3) step();
        chk("t4_full_period", u_if.count_val, saved);
        step();
        chk("t4_inc", u_if.count_val, saved + 32'd1);

        // 5: long load request
        ack_base = n_ack;
        u_if.load_req = 1; u_if.load_val = 32'hCAFE_0001;
        repeat (10) step();
        chk("t5_one_ack", n_ack - ack_base, 1);
        chk("t5_hold", u_if.count_val, 32'hCAFE_0001);
        u_if.load_req = 0;
        repeat (6) step();
        chk("t5_resume", u_if.count_val, 32'hCAFE_0002);

        // 6: reset during LOAD
        u_if.load_req = 1; u_if.load_val = 32'hAAAA_5555;
        step();
        chk("t6_in_load", m_mode, 2);
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        u_if.load_req = 0; u_if.cnt_en_req = 0;
        ack_base = n_ack;
        step(); step();
        rst_n = 1'b1;
        repeat (8) step();
        chk("t6_no_ack", n_ack - ack_base, 0);
        chk("t6_idle", u_if.cnt_en, 1'b0);

        // randomized traffic
        u_if.cnt_en_req = 1;
        for (int i = 0; i < 3000; i++) begin
            if (u_if.load_req && m_ack) u_if.load_req = 0;
            else if (!u_if.load_req && m_mode != 3 && $urandom_range(0, 24) == 0) begin
                u_if.load_req = 1;
                u_if.load_val = ($urandom_range(0, 1) == 1) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                             : $urandom;
            end
            if ($urandom_range(0, 29) == 0) u_if.cnt_en_req = ~u_if.cnt_en_req;
            if ($urandom_range(0, 49) == 0) u_if.prescale_val = 16'($urandom_range(0, 4));
            u_if.wrap_clr = ($urandom_range(0, 9) == 0);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
